// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-byte SPI master engine
//
// Ports:
//   i_Clk       system clock, all logic on the rising edge
//   i_Rst_L     asynchronous reset, active high
//   i_TX_Byte   byte to send, captured when the request is accepted
//   i_TX_DV     send request, taken only while o_TX_Ready is high
//   o_TX_Ready  engine idle, able to accept a byte
//   o_RX_DV     one-cycle strobe qualifying o_RX_Byte
//   o_RX_Byte   last completed received byte
//   o_SPI_Clk   SPI clock, idles at CPOL
//   i_SPI_MISO  serial data from slave
//   o_SPI_MOSI  serial data to slave, MSB first

module spi_master #(
   parameter int SPI_MODE          = 0,
   parameter int CLKS_PER_HALF_BIT = 2
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic [7:0] i_TX_Byte,
   input  logic       i_TX_DV,
   output logic       o_TX_Ready,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte,
   output logic       o_SPI_Clk,
   input  logic       i_SPI_MISO,
   output logic       o_SPI_MOSI
);

   localparam logic [1:0] MODE = 2'(SPI_MODE);
   localparam logic       CPOL = MODE[1];
   localparam logic       CPHA = MODE[0];

   localparam int              HB_W   = $clog2(CLKS_PER_HALF_BIT);
   localparam logic [HB_W-1:0] HB_MAX = HB_W'(CLKS_PER_HALF_BIT - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]      state_q,    state_d;
   logic [HB_W-1:0] hb_q,       hb_d;
   logic [4:0]      edge_q,     edge_d;
   logic [7:0]      tx_byte_q,  tx_byte_d;
   logic [2:0]      tx_bit_q,   tx_bit_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic            fin_q,      fin_d;
   logic            rx_dv_q,    rx_dv_d;
   logic [7:0]      rx_byte_q,  rx_byte_d;
   logic            sck_q,      sck_d;
   logic            mosi_q,     mosi_d;

   logic       accept;
   logic       lead_edge;
   logic       samp_edge;
   logic       shift_edge;
   logic [2:0] tx_bit_m1;

   assign accept    = (state_q == ST_IDLE) && i_TX_DV;
   assign tx_bit_m1 = tx_bit_q - 3'd1;

   // edge_q holds 16..1 before a toggle, so the edge number is 17 - edge_q:
   // an even count marks an odd-numbered (leading) edge.
   assign lead_edge  = ~edge_q[0];
   assign samp_edge  = lead_edge ^ CPHA;
   // CPHA=0 has already presented bit 7 at acceptance, so its final trailing
   // edge (edge 16) has no further bit to shift out.
   assign shift_edge = ~samp_edge && (CPHA || (edge_q != 5'd1));

   always_comb begin
      state_d    = state_q;
      hb_d       = hb_q;
      edge_d     = edge_q;
      tx_byte_d  = tx_byte_q;
      tx_bit_d   = tx_bit_q;
      rx_shift_d = rx_shift_q;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      fin_d      = 1'b0;
      // completion is published one cycle after the last SPI edge
      rx_dv_d    = fin_q;
      rx_byte_d  = fin_q ? rx_shift_q : rx_byte_q;

      if (accept) begin
         state_d   = ST_BUSY;
         hb_d      = '0;
         edge_d    = 5'd16;
         tx_byte_d = i_TX_Byte;
         tx_bit_d  = 3'd7;
         if (!CPHA) begin
            mosi_d = i_TX_Byte[7];
         end
      end else if (state_q == ST_BUSY) begin
         if (hb_q == HB_MAX) begin
            hb_d   = '0;
            sck_d  = ~sck_q;
            edge_d = edge_q - 5'd1;
            if (samp_edge) begin
               rx_shift_d = {rx_shift_q[6:0], i_SPI_MISO};
            end
            if (shift_edge) begin
               mosi_d   = CPHA ? tx_byte_q[tx_bit_q] : tx_byte_q[tx_bit_m1];
               tx_bit_d = tx_bit_m1;
            end
            if (edge_q == 5'd1) begin
               state_d = ST_IDLE;
               fin_d   = 1'b1;
            end
         end else begin
            hb_d = hb_q + HB_W'(1);
         end
      end
   end

   always_ff @(posedge i_Clk or posedge i_Rst_L) begin
      if (i_Rst_L) begin
         state_q    <= ST_IDLE;
         hb_q       <= '0;
         edge_q     <= '0;
         tx_byte_q  <= '0;
         tx_bit_q   <= '0;
         rx_shift_q <= '0;
         fin_q      <= 1'b0;
         rx_dv_q    <= 1'b0;
         rx_byte_q  <= '0;
         sck_q      <= CPOL;
         mosi_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hb_q       <= hb_d;
         edge_q     <= edge_d;
         tx_byte_q  <= tx_byte_d;
         tx_bit_q   <= tx_bit_d;
         rx_shift_q <= rx_shift_d;
         fin_q      <= fin_d;
         rx_dv_q    <= rx_dv_d;
         rx_byte_q  <= rx_byte_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
      end
   end

   assign o_TX_Ready = (state_q == ST_IDLE);
   assign o_RX_DV    = rx_dv_q;
   assign o_RX_Byte  = rx_byte_q;
   assign o_SPI_Clk  = sck_q;
   assign o_SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master
module tb_spi_master;

   localparam int NI = 5;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic [7:0] tx_byte   = 8'h00;
   logic       tx_dv     = 1'b0;
   logic [2:0] sel       = 3'd0;
   logic       loop      = 1'b1;
   logic [7:0] s_byte_in = 8'h00;
   logic       miso;

   logic       ready_a   [NI];
   logic       rx_dv_a   [NI];
   logic [7:0] rx_byte_a [NI];
   logic       sck_a     [NI];
   logic       mosi_a    [NI];

   logic       ready, rx_dv, sck, mosi;
   logic [7:0] rx_byte;

   always #5 clk = ~clk;

   function automatic logic [1:0] mode_of(input logic [2:0] k);
      return (k == 3'd4) ? 2'd0 : k[1:0];
   endfunction

   for (genvar k = 0; k < NI; k++) begin : g_dut
      spi_master #(
         .SPI_MODE          ((k == 4) ? 0 : k),
         .CLKS_PER_HALF_BIT ((k == 4) ? 4 : 2)
      ) u_dut (
         .i_Clk      (clk),
         .i_Rst_L    (rst),
         .i_TX_Byte  (tx_byte),
         .i_TX_DV    (tx_dv && (sel == 3'(k))),
         .o_TX_Ready (ready_a[k]),
         .o_RX_DV    (rx_dv_a[k]),
         .o_RX_Byte  (rx_byte_a[k]),
         .o_SPI_Clk  (sck_a[k]),
         .i_SPI_MISO (miso),
         .o_SPI_MOSI (mosi_a[k])
      );
   end

   always_comb begin
      ready   = ready_a[sel];
      rx_dv   = rx_dv_a[sel];
      rx_byte = rx_byte_a[sel];
      sck     = sck_a[sel];
      mosi    = mosi_a[sel];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor and behavioural slave, evaluated mid-cycle.
   logic       sck_p   = 1'b0;
   logic       mosi_p  = 1'b0;
   logic       s_miso  = 1'b0;
   logic [7:0] s_sh    = 8'h00;
   logic [7:0] mcap    = 8'h00;
   int         tog     = 0;
   int         viol    = 0;
   int         t_first = 0;
   int         t_third = 0;
   int         rx_n    = 0;
   logic [7:0] log_byte [$];
   int         log_cyc  [$];
   logic       log_rdy  [$];

   assign miso = loop ? mosi : s_miso;

   always @(negedge clk) begin
      logic [1:0] m;
      logic       lead;
      m = mode_of(sel);
      if (tx_dv && ready) begin
         tog  = 0;
         viol = 0;
         mcap = 8'h00;
         s_sh = s_byte_in;
         if (!m[0]) s_miso = s_byte_in[7];
      end else if (sck !== sck_p) begin
         tog  = tog + 1;
         lead = (sck != m[1]);
         if (tog == 1) t_first = cyc;
         if (tog == 3) t_third = cyc;
         if (lead != m[0]) begin
            mcap = {mcap[6:0], mosi};
            if (mosi !== mosi_p) viol = viol + 1;
         end else if (m[0]) begin
            s_miso = s_sh[7];
            s_sh   = s_sh << 1;
         end else if (tog < 16) begin
            s_sh   = s_sh << 1;
            s_miso = s_sh[7];
         end
      end
      if (rx_dv === 1'b1) begin
         log_byte.push_back(rx_byte);
         log_cyc.push_back(cyc);
         log_rdy.push_back(ready);
         rx_n = rx_n + 1;
      end
      sck_p  = sck;
      mosi_p = mosi;
   end

   int n_vec  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic [7:0] b, input logic [7:0] sb, input logic lp,
                       output int a_cyc, output bit ok);
      int w;
      loop      = lp;
      s_byte_in = sb;
      w = 0;
      while (ready !== 1'b1 && w < 100) begin
         step();
         w++;
      end
      tx_byte = b;
      tx_dv   = 1'b1;
      step();
      a_cyc = cyc;
      tx_dv = 1'b0;
      ok    = (w < 100);
   endtask

   task automatic wait_rx(input int n0, input int limit, output bit ok);
      int w;
      w = 0;
      while (rx_n <= n0 && w < limit) begin
         step();
         w++;
      end
      ok = (rx_n > n0);
   endtask

   task automatic check_xfer(input string tag, input logic [7:0] b, input logic [7:0] sb,
                             input logic lp);
      int         a, n0, h;
      bit         ok;
      logic [1:0] m;
      logic [7:0] exp_rx;
      m      = mode_of(sel);
      h      = (sel == 3'd4) ? 4 : 2;
      exp_rx = lp ? b : sb;
      chk({tag, "_idle_sck"}, 32'(sck), 32'(m[1]));
      n0 = rx_n;
      xfer(b, sb, lp, a, ok);
      chk({tag, "_accept"}, 32'(ok), 32'd1);
      chk({tag, "_busy"}, 32'(ready), 32'd0);
      wait_rx(n0, 40 * h, ok);
      chk({tag, "_done"}, 32'(ok), 32'd1);
      chk({tag, "_latency"}, 32'(log_cyc[n0] - a), 32'(16 * h + 1));
      chk({tag, "_rx_byte"}, 32'(log_byte[n0]), 32'(exp_rx));
      chk({tag, "_ready_at_dv"}, 32'(log_rdy[n0]), 32'd1);
      chk({tag, "_mosi_bits"}, 32'(mcap), 32'(b));
      chk({tag, "_toggles"}, 32'(tog), 32'd16);
      chk({tag, "_mosi_on_sample_edge"}, 32'(viol), 32'd0);
      chk({tag, "_sck_park"}, 32'(sck), 32'(m[1]));
      chk({tag, "_sck_period"}, 32'(t_third - t_first), 32'(2 * h));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         ok;
      int         a, n0, w;
      logic [7:0] b, sb;
      logic [7:0] bb [3];
      logic       lp;
      bb = '{8'h00, 8'hFF, 8'h81};

      rst = 1'b1;
      repeat (3) step();
      for (int k = 0; k < NI; k++) begin
         sel = 3'(k);
         #1;
         chk("rst_ready", 32'(ready), 32'd1);
         chk("rst_rx_dv", 32'(rx_dv), 32'd0);
         chk("rst_rx_byte", 32'(rx_byte), 32'd0);
         chk("rst_sck", 32'(sck), 32'(mode_of(sel) >> 1));
         chk("rst_mosi", 32'(mosi), 32'd0);
      end
      sel = 3'd0;
      rst = 1'b0;
      repeat (2) step();

      // mode 0, loopback
      check_xfer("m0_a5", 8'hA5, 8'h00, 1'b1);

      // modes 1..3 against a slave responder
      for (int k = 1; k < 4; k++) begin
         sel = 3'(k);
         step();
         check_xfer("mode_c3", 8'hC3, 8'h3C, 1'b0);
      end

      // randomised traffic on every instance
      for (int k = 0; k < NI; k++) begin
         sel = 3'(k);
         step();
         for (int r = 0; r < 3; r++) begin
            b  = 8'($urandom);
            sb = 8'($urandom);
            lp = 1'($urandom_range(0, 1));
            check_xfer("rand", b, sb, lp);
         end
      end

      // request while busy is ignored
      sel = 3'd0;
      step();
      b  = 8'($urandom);
      sb = 8'($urandom);
      n0 = rx_n;
      xfer(b, sb, 1'b0, a, ok);
      repeat (10) step();
      tx_byte = 8'hFF;
      tx_dv   = 1'b1;
      step();
      tx_dv = 1'b0;
      wait_rx(n0, 80, ok);
      chk("ign_done", 32'(ok), 32'd1);
      chk("ign_rx_byte", 32'(log_byte[n0]), 32'(sb));
      chk("ign_mosi_bits", 32'(mcap), 32'(b));
      repeat (40) step();
      chk("ign_one_pulse", 32'(rx_n), 32'(n0 + 1));

      // back-to-back on the first ready cycle
      n0 = rx_n;
      for (int i = 0; i < 3; i++) begin
         xfer(bb[i], 8'h00, 1'b1, a, ok);
         chk("b2b_accept", 32'(ok), 32'd1);
      end
      wait_rx(n0 + 2, 80, ok);
      chk("b2b_done", 32'(ok), 32'd1);
      for (int i = 0; i < 3; i++) begin
         chk("b2b_rx_byte", 32'(log_byte[n0 + i]), 32'(bb[i]));
      end
      chk("b2b_gap1", 32'(log_cyc[n0 + 1] - log_cyc[n0]), 32'd33);
      chk("b2b_gap2", 32'(log_cyc[n0 + 2] - log_cyc[n0 + 1]), 32'd33);

      // reset in the middle of a transfer
      repeat (5) step();
      b = 8'($urandom);
      xfer(b, 8'h00, 1'b1, a, ok);
      w = 0;
      while (tog < 7 && w < 100) begin
         step();
         w++;
      end
      chk("rst_mid_edge7", 32'(tog), 32'd7);
      n0  = rx_n;
      rst = 1'b1;
      #1;
      chk("rst_mid_sck", 32'(sck), 32'd0);
      chk("rst_mid_ready", 32'(ready), 32'd1);
      chk("rst_mid_rx_byte", 32'(rx_byte), 32'd0);
      chk("rst_mid_rx_dv", 32'(rx_dv), 32'd0);
      chk("rst_mid_mosi", 32'(mosi), 32'd0);
      repeat (3) step();
      rst = 1'b0;
      repeat (40) step();
      chk("rst_mid_no_dv", 32'(rx_n), 32'(n0));
      check_xfer("after_rst", 8'($urandom), 8'h00, 1'b1);

      // half-period of four system clocks
      sel = 3'd4;
      step();
      check_xfer("h4", 8'h5A, 8'hE1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
